// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Monitor-side decoder for an active-low, multiplexed seven-segment bus.
// The bus {an, seg, dp} is registered every clock; once a sample has been
// held unchanged for STABLE_CYCLES samples it is captured exactly once and
// decoded into a per-position octal digit, decimal point and validity.
// A per-position down counter marks a position stale (valid cleared) when it
// has not been captured for TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   seg[6:0]  in   {CG..CA}, active-low
//   dp        in   decimal point, active-low
//   an[3:0]   in   {AN3..AN0}, active-low
//   digits    out  decoded octal value, digits[3i+2:3i] for AN i
//   dp_lit    out  decimal point lit per position
//   valid     out  legal, fresh, non-blank digit per position
//   err       out  last capture at position was illegal
//   conflict  out  1-cycle pulse: stable sample had several anodes low
//   upd       out  1-cycle pulse: capture this cycle
//   upd_idx   out  captured position (meaningful while upd = 1)
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [3:0]  an,
    output logic [11:0] digits,
    output logic [3:0]  dp_lit,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        conflict,
    output logic        upd,
    output logic [1:0]  upd_idx
);

    localparam logic [7:0]  STABLE_W = 8'(STABLE_CYCLES);
    localparam logic [15:0] TMO_W    = 16'(TIMEOUT_CYCLES);

    // Sample register layout: {an[3:0], seg[6:0], dp}
    logic [11:0]       samp_q, samp_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [3:0][15:0]  tmo_q, tmo_d;

    logic [11:0] digits_q, digits_d;
    logic [3:0]  dp_lit_q, dp_lit_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  err_q, err_d;
    logic        conflict_q, conflict_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;

    logic        fire;
    logic [3:0]  an_l;
    logic [6:0]  seg_s;
    logic        one_hot;
    logic        multi;
    logic [1:0]  idx;
    logic [2:0]  dec_val;
    logic        dec_legal;
    logic        dec_blank;

    always_comb begin
        samp_d = {an, seg, dp};

        // Capture decision uses the held sample and count, so the capture
        // lands one edge after the STABLE_CYCLES-th identical sample.
        fire = armed_q && (cnt_q == STABLE_W);

        if (samp_d == samp_q) begin
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            armed_d = fire ? 1'b0 : armed_q;
        end else begin
            // A new value always re-arms, even if a capture fires this cycle.
            cnt_d   = 8'd1;
            armed_d = 1'b1;
        end

        an_l    = ~samp_q[11:8];
        seg_s   = samp_q[7:1];
        one_hot = (an_l != 4'd0) && ((an_l & (an_l - 4'd1)) == 4'd0);
        multi   = (an_l != 4'd0) && !one_hot;

        idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (an_l[i]) idx = 2'(i);
        end

        dec_val   = 3'd0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (seg_s)
            7'h40: dec_val = 3'd0;
            7'h79: dec_val = 3'd1;
            7'h24: dec_val = 3'd2;
            7'h30: dec_val = 3'd3;
            7'h19: dec_val = 3'd4;
            7'h12: dec_val = 3'd5;
            7'h02: dec_val = 3'd6;
            7'h78: dec_val = 3'd7;
            7'h7F: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase

        digits_d   = digits_q;
        dp_lit_d   = dp_lit_q;
        valid_d    = valid_q;
        err_d      = err_q;
        conflict_d = 1'b0;
        upd_d      = 1'b0;
        upd_idx_d  = upd_idx_q;
        tmo_d      = tmo_q;

        for (int unsigned i = 0; i < 4; i++) begin
            if (tmo_q[i] != 16'd0) begin
                tmo_d[i] = tmo_q[i] - 16'd1;
                if (tmo_q[i] == 16'd1) valid_d[i] = 1'b0;
            end
        end

        // Capture is applied after the timeout step so it wins on collision.
        if (fire && one_hot) begin
            upd_d     = 1'b1;
            upd_idx_d = idx;
            for (int unsigned i = 0; i < 4; i++) begin
                if (2'(i) == idx) begin
                    tmo_d[i]    = TMO_W;
                    dp_lit_d[i] = ~samp_q[0];
                    valid_d[i]  = dec_legal;
                    err_d[i]    = !dec_legal && !dec_blank;
                    if (dec_legal) digits_d[3*i +: 3] = dec_val;
                end
            end
        end

        if (fire && multi) conflict_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q     <= '1;
            cnt_q      <= '0;
            armed_q    <= 1'b1;
            tmo_q      <= {4{TMO_W}};
            digits_q   <= '0;
            dp_lit_q   <= '0;
            valid_q    <= '0;
            err_q      <= '0;
            conflict_q <= 1'b0;
            upd_q      <= 1'b0;
            upd_idx_q  <= '0;
        end else begin
            samp_q     <= samp_d;
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            tmo_q      <= tmo_d;
            digits_q   <= digits_d;
            dp_lit_q   <= dp_lit_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            conflict_q <= conflict_d;
            upd_q      <= upd_d;
            upd_idx_q  <= upd_idx_d;
        end
    end

    assign digits   = digits_q;
    assign dp_lit   = dp_lit_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign conflict = conflict_q;
    assign upd      = upd_q;
    assign upd_idx  = upd_idx_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder. Expected capture/conflict events are
// predicted from the stimulus and queued; a monitor queues what the DUT
// reports, and each test pops and compares both queues.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    logic [11:0] digits;
    logic [3:0]  dp_lit, valid, err;
    logic        conflict, upd;
    logic [1:0]  upd_idx;

    logic [11:0] t_digits;
    logic [3:0]  t_dp_lit, t_valid, t_err;
    logic        t_conflict, t_upd;
    logic [1:0]  t_upd_idx;

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(65535)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .an(an),
        .digits(digits), .dp_lit(dp_lit), .valid(valid), .err(err),
        .conflict(conflict), .upd(upd), .upd_idx(upd_idx)
    );

    seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_t (
        .clk(clk), .rst_n(rst_n), .seg(seg), .dp(dp), .an(an),
        .digits(t_digits), .dp_lit(t_dp_lit), .valid(t_valid), .err(t_err),
        .conflict(t_conflict), .upd(t_upd), .upd_idx(t_upd_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        upd;
        logic        conf;
        logic [1:0]  idx;
        logic [11:0] digits;
        logic [3:0]  valid;
        logic [3:0]  err;
        logic [3:0]  dpl;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state for the main instance
    logic [11:0] m_digits;
    logic [3:0]  m_valid, m_err, m_dpl;
    logic [11:0] last_bus;
    logic [31:0] last_cap;

    logic [6:0] pat [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (upd === 1'b1 || conflict === 1'b1)) begin
            ev_t o;
            o.upd    = upd;
            o.conf   = conflict;
            o.idx    = upd ? upd_idx : 2'd0;
            o.digits = digits;
            o.valid  = valid;
            o.err    = err;
            o.dpl    = dp_lit;
            o.cyc    = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic model_reset();
        m_digits = '0;
        m_valid  = '0;
        m_err    = '0;
        m_dpl    = '0;
        last_bus = '1;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Drive a bus value for n cycles starting at the current negedge and
    // queue the event it should produce.
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        logic [3:0] anl;
        ev_t        e;
        int         ix;
        int         val;
        an  = a;
        seg = s;
        dp  = d;
        if ({a, s, d} != last_bus && n >= STABLE) begin
            anl      = ~a;
            e        = '0;
            e.cyc    = cyc + STABLE + 1;
            last_cap = e.cyc;
            if (anl != 4'd0) begin
                if ($countones(anl) > 1) begin
                    e.conf = 1'b1;
                end else begin
                    ix = 0;
                    for (int i = 0; i < 4; i++) if (anl[i]) ix = i;
                    val = -1;
                    for (int v = 0; v < 8; v++) if (pat[v] == s) val = v;
                    if (val >= 0) begin
                        m_digits[3*ix +: 3] = 3'(val);
                        m_valid[ix] = 1'b1;
                        m_err[ix]   = 1'b0;
                    end else begin
                        m_valid[ix] = 1'b0;
                        m_err[ix]   = (s != 7'h7F);
                    end
                    m_dpl[ix] = ~d;
                    e.upd = 1'b1;
                    e.idx = 2'(ix);
                end
                e.digits = m_digits;
                e.valid  = m_valid;
                e.err    = m_err;
                e.dpl    = m_dpl;
                exp_q.push_back(e);
            end
        end
        last_bus = {a, s, d};
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            an  = 4'($urandom);
            seg = 7'($urandom);
            dp  = 1'($urandom);
            @(negedge clk);
            n_checks++;
            if ({digits, dp_lit, valid, err, conflict, upd, upd_idx} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h required 0",
                         {digits, dp_lit, valid, err, conflict, upd, upd_idx});
            end
            n_checks++;
            if ({t_digits, t_dp_lit, t_valid, t_err, t_conflict, t_upd, t_upd_idx} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs_t: got %h required 0",
                         {t_digits, t_dp_lit, t_valid, t_err, t_conflict, t_upd, t_upd_idx});
            end
        end
        rst_n = 1'b1;
        hold(4'b1110, 7'h24, 1'b1, 4);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL reset_event_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_release_event: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_full_scan();
        hold(4'b1110, 7'h79, 1'b1, 8);
        hold(4'b1101, 7'h30, 1'b1, 8);
        hold(4'b1011, 7'h12, 1'b0, 8);
        hold(4'b0111, 7'h78, 1'b1, 8);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != 4 || exp_q.size() != 4) begin
            n_fail++;
            $display("FAIL scan_event_count: got %0d required 4", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL scan_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (digits !== 12'o7531 || valid !== 4'b1111 || dp_lit !== 4'b0100) begin
            n_fail++;
            $display("FAIL scan_final: got digits=%o valid=%b dp_lit=%b required 7531 1111 0100",
                     digits, valid, dp_lit);
        end
    endtask

    task automatic test_glitch();
        hold(4'b1101, 7'h40, 1'b1, 3);
        hold(4'b1101, 7'h19, 1'b1, 4);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL glitch_event_count: got %0d required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL glitch_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (digits[5:3] !== 3'd4) begin
            n_fail++;
            $display("FAIL glitch_digit: got %0d required 4", digits[5:3]);
        end
    endtask

    task automatic test_illegal_blank();
        hold(4'b1011, 7'h55, 1'b1, 4);
        hold(4'b1011, 7'h7F, 1'b1, 6);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++;
            $display("FAIL illegal_event_count: got %0d required 2", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL illegal_blank_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (digits[8:6] !== 3'd5 || err !== 4'b0000 || valid[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_final: got d=%0d err=%b v2=%b required 5 0000 0",
                     digits[8:6], err, valid[2]);
        end
    endtask

    task automatic test_conflict();
        hold(4'b1100, 7'h40, 1'b1, 4);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL conflict_event_count: got %0d required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL conflict_event: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        hold(4'b1101, 7'h30, 1'b1, 2);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({digits, valid, err, dp_lit, upd} !== '0) begin
            n_fail++;
            $display("FAIL midhold_reset: got %h required 0", {digits, valid, err, dp_lit, upd});
        end
        rst_n = 1'b1;
        hold(4'b1101, 7'h30, 1'b1, 4);
        hold(4'b1111, 7'h7F, 1'b1, 2);
        n_checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++;
            $display("FAIL midhold_event_count: got %0d required 1", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midhold_event: got %h required %h", o, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] cap;
        hold(4'b0111, 7'h02, 1'b1, 4);
        cap = last_cap;
        an = 4'b1111; seg = 7'h7F; dp = 1'b1; last_bus = '1;
        while (cyc < cap) @(negedge clk);
        n_checks++;
        if (t_valid[3] !== 1'b1 || t_digits[11:9] !== 3'd6) begin
            n_fail++;
            $display("FAIL timeout_capture: got v=%b d=%0d required 1 6", t_valid[3], t_digits[11:9]);
        end
        while (cyc < cap + 19) @(negedge clk);
        n_checks++;
        if (t_valid[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got %b required 1", t_valid[3]);
        end
        @(negedge clk);
        n_checks++;
        if (t_valid[3] !== 1'b0 || t_digits[11:9] !== 3'd6) begin
            n_fail++;
            $display("FAIL timeout_expire: got v=%b d=%0d required 0 6", t_valid[3], t_digits[11:9]);
        end
        n_checks++;
        if (valid[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL long_timeout_hold: got %b required 1", valid[3]);
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o = obs_q.pop_front();
            ev_t e = exp_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_event: got %h required %h", o, e);
            end
        end
        n_checks++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events: got %0d/%0d required 0/0", obs_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_glitch();
        test_illegal_blank();
        test_conflict();
        test_reset_mid_hold();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Monitor-side decoder for the active-low, multiplexed seven-segment bus (segments CA–CG, DP, anodes AN3–AN0) driven by the board's octal display drivers. It samples the bus every clock, waits for each anode strobe to settle, and decodes the segment pattern back into an octal digit, decimal-point state and validity per display position. It sits beside the display driver in loopback builds and in self-check benches, closing the loop on what the panel actually shows.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a capture (range 1–255).
- TIMEOUT_CYCLES, 65535: cycles without a strobe on a position before that position is marked stale (range 1–65535).
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is externally synchronised to clk.
- seg  in  7  segment bus {CG,CF,CE,CD,CC,CB,CA}, active-low (0 = lit).
- dp  in  1  decimal-point line, active-low.
- an  in  4  anodes {AN3..AN0}, active-low (0 = position enabled).
- digits  out  12  decoded octal value per position; digits[3i+2:3i] belongs to AN i.
- dp_lit  out  4  1 = decimal point lit at position i.
- valid  out  4  1 = position i holds a legal, fresh, non-blank digit.
- err  out  4  1 = last capture at position i was an illegal pattern (sticky until next capture at i).
- conflict  out  1  1-cycle pulse: a stable sample showed more than one anode low.
- upd  out  1  1-cycle pulse: a capture occurred this cycle.
- upd_idx  out  2  position captured; valid only while upd = 1.

## Operation
- Legal patterns (seg, hex): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78. Blank: 7F. Anything else is illegal.
- Input stage: {an, seg, dp} registered each edge into a sample register; a stability counter (8-bit, saturating) compares each new sample to the held one: equal → increment, different → load new value, counter = 1.
- Capture fires once per stable hold, when counter reaches STABLE_CYCLES; further identical samples do not re-fire. A change followed by return to the old value re-arms.
- At capture, classify anodes:
  - exactly one low (index i): decode. Legal → digits[i] = value, valid[i] = 1, err[i] = 0. Blank → digits[i] unchanged, valid[i] = 0, err[i] = 0. Illegal → digits[i] unchanged, valid[i] = 0, err[i] = 1. dp_lit[i] = ~dp in all three cases. upd = 1, upd_idx = i; position i's timeout counter reloads.
  - all high: idle; no capture, no pulse.
  - two or more low: conflict = 1; no position updated; upd = 0.
- Timeout: per-position 16-bit down counter, reloaded with TIMEOUT_CYCLES at each capture of that position, decremented otherwise; on reaching 0, valid[i] cleared (digits, err, dp_lit held) and counter stays at 0 until next capture.
- Capture and timeout expiry on the same position in the same cycle: capture wins.

## Timing
- Reset (async, rst_n = 0): digits = 0, dp_lit = 0, valid = 0, err = 0, conflict = 0, upd = 0, upd_idx = 0; sample register = all-ones (idle bus), stability counter = 0, capture armed, timeout counters = TIMEOUT_CYCLES.
- Latency: bus value constant and present before edge 1 is sampled at edges 1..STABLE_CYCLES; outputs and upd/conflict update at edge STABLE_CYCLES+1 (STABLE_CYCLES = 4 → 5 cycles).
- upd and conflict are exactly one cycle wide; back-to-back captures on successive cycles are impossible for STABLE_CYCLES ≥ 2, and for STABLE_CYCLES = 1 each change yields one pulse.
- Any bus change at or before the capturing sample aborts that capture and restarts counting.
- Reset mid-hold: counting restarts from zero after release; no partial capture survives.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n = 0 with random bus -> all outputs 0; release with an = 1110, seg = 24, dp = 1 for 4 cycles -> upd pulse at edge 5, upd_idx = 0, digits[2:0] = 2, valid = 0001, dp_lit = 0000.
- Full scan: cycle an through 1110/1101/1011/0111 with seg 79/30/12/78, dp = 0 on AN2, 8 cycles each -> digits = {7,5,3,1} (12'o7531), valid = 1111, dp_lit = 0100, four upd pulses.
- Glitch filter: an = 1101, seg = 40 held 3 cycles then seg = 19 held 4 -> no capture for 40; one capture with digits[5:3] = 4.
- Illegal/blank: an = 1011, seg = 55 held 4 -> err = 0100, valid[2] = 0, digits[8:6] unchanged; then seg = 7F -> err[2] = 0, valid[2] = 0.
- Conflict: an = 1100, seg = 40 held 4 -> conflict pulse at edge 5, upd = 0, no output change.
- Timeout: TIMEOUT_CYCLES = 20, capture digit 6 on AN3, then idle bus -> valid[3] falls exactly 20 cycles after the capture edge, digits[11:9] stays 6.
